// File: rtl/cva6_clic_target.sv
// Per-hart CLIC target: presents the arbitration winner to the core, withdraws it via kill handshake, reports claims.
// Optional kill-handshake timeout flag enabled by defining CVA6_CLIC_KILL_TIMEOUT_EN.
module cva6_clic_target #(
  parameter int unsigned NumSrc      = 256,
  parameter int unsigned IdWidth     = $clog2(NumSrc),
  parameter int unsigned LevelWidth  = 8,
  parameter int unsigned KillTimeout = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  arb_valid_i,
  input  logic [IdWidth-1:0]    arb_id_i,
  input  logic [LevelWidth-1:0] arb_level_i,
  input  logic [1:0]            arb_priv_i,
  output logic                  irq_valid_o,
  output logic [IdWidth-1:0]    irq_id_o,
  output logic [LevelWidth-1:0] irq_level_o,
  output logic [1:0]            irq_priv_o,
  input  logic                  irq_ready_i,
  output logic                  kill_req_o,
  input  logic                  kill_ack_i,
  output logic                  claim_valid_o,
  output logic [IdWidth-1:0]    claim_id_o,
  output logic                  kill_timeout_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, KILL, CLAIM} state_e;

  state_e                state_q, state_d;
  logic [IdWidth-1:0]    id_q, id_d;
  logic [LevelWidth-1:0] level_q, level_d;
  logic [1:0]            priv_q, priv_d;
  logic                  present_d;

  if (KillTimeout < 1) begin : g_bad_cfg
    $error("KillTimeout must be at least 1");
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    level_d = level_q;
    priv_d  = priv_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_i) begin
          state_d = ACCESS;
          id_d    = arb_id_i;
          level_d = arb_level_i;
          priv_d  = arb_priv_i;
        end
      end
      ACCESS: begin
        // acceptance beats a simultaneous winner change
        if (irq_ready_i) begin
          state_d = CLAIM;
        end else if (!arb_valid_i || (arb_id_i != id_q)) begin
          state_d = KILL;
        end
      end
      KILL: begin
        if (irq_ready_i) begin
          state_d = CLAIM;
        end else if (kill_ack_i) begin
          state_d = IDLE;
        end
      end
      CLAIM:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign present_d = (state_d == ACCESS) || (state_d == KILL);

  // outputs are registered from the next-state decode so they change with the state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      id_q          <= '0;
      level_q       <= '0;
      priv_q        <= '0;
      irq_valid_o   <= 1'b0;
      irq_id_o      <= '0;
      irq_level_o   <= '0;
      irq_priv_o    <= '0;
      kill_req_o    <= 1'b0;
      claim_valid_o <= 1'b0;
      claim_id_o    <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      level_q       <= level_d;
      priv_q        <= priv_d;
      irq_valid_o   <= (state_d == ACCESS);
      irq_id_o      <= present_d ? id_d : '0;
      irq_level_o   <= present_d ? level_d : '0;
      irq_priv_o    <= present_d ? priv_d : '0;
      kill_req_o    <= (state_d == KILL);
      claim_valid_o <= (state_d == CLAIM);
      claim_id_o    <= (state_d == CLAIM) ? id_d : '0;
    end
  end

`ifdef CVA6_CLIC_KILL_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(KillTimeout + 1);

  logic [CntWidth-1:0] kill_cnt_q;

  // counter sits at zero outside KILL, so it is clear on every entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kill_cnt_q     <= '0;
      kill_timeout_o <= 1'b0;
    end else begin
      if (state_q != KILL) begin
        kill_cnt_q <= '0;
      end else if (kill_cnt_q != CntWidth'(KillTimeout)) begin
        kill_cnt_q <= kill_cnt_q + 1'b1;
      end
      if ((state_q == KILL) && (kill_cnt_q == CntWidth'(KillTimeout - 1))) begin
        kill_timeout_o <= 1'b1;
      end
    end
  end
`else
  assign kill_timeout_o = 1'b0;
`endif

`ifndef SYNTHESIS
  a_ready_in_access_or_kill : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(irq_ready_i && ((state_q == IDLE) || (state_q == CLAIM))));
  a_valid_kill_exclusive : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(irq_valid_o && kill_req_o));
  a_claim_not_back_to_back : assert property (@(posedge clk_i) disable iff (!rst_ni)
    claim_valid_o |=> !claim_valid_o);
`endif

endmodule

// File: tb/tb_cva6_clic_target.sv
// Self-checking bench for cva6_clic_target: cycle vectors with a scoreboard queue,
// plus hand-written reset and kill-timeout sequences.
module tb_cva6_clic_target;

`ifdef CVA6_CLIC_KILL_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arb_valid = 1'b0;
  logic [7:0] arb_id = '0;
  logic [7:0] arb_level = '0;
  logic [1:0] arb_priv = '0;
  logic       irq_ready = 1'b0;
  logic       kill_ack = 1'b0;
  logic       irq_valid, kill_req, claim_valid, kill_timeout;
  logic [7:0] irq_id, irq_level, claim_id;
  logic [1:0] irq_priv;

  always #5 clk = ~clk;

  cva6_clic_target #(.NumSrc(256), .LevelWidth(8), .KillTimeout(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .arb_valid_i(arb_valid), .arb_id_i(arb_id), .arb_level_i(arb_level), .arb_priv_i(arb_priv),
    .irq_valid_o(irq_valid), .irq_id_o(irq_id), .irq_level_o(irq_level), .irq_priv_o(irq_priv),
    .irq_ready_i(irq_ready), .kill_req_o(kill_req), .kill_ack_i(kill_ack),
    .claim_valid_o(claim_valid), .claim_id_o(claim_id), .kill_timeout_o(kill_timeout)
  );

  typedef struct {
    logic       av;
    logic [7:0] id;
    logic [7:0] lvl;
    logic [1:0] pr;
    logic       rdy;
    logic       ack;
    logic       e_v;
    logic [7:0] e_id;
    logic [7:0] e_lvl;
    logic [1:0] e_pr;
    logic       e_kill;
    logic       e_claim;
    logic [7:0] e_cid;
    logic       e_to;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic vec_t mk(bit av, int id, int lvl, int pr, bit rdy, bit ack,
                              bit ev, int eid, int elvl, int epr, bit ek, bit ec, int ecid);
    vec_t v;
    v.av = av; v.id = 8'(id); v.lvl = 8'(lvl); v.pr = 2'(pr); v.rdy = rdy; v.ack = ack;
    v.e_v = ev; v.e_id = 8'(eid); v.e_lvl = 8'(elvl); v.e_pr = 2'(epr);
    v.e_kill = ek; v.e_claim = ec; v.e_cid = 8'(ecid); v.e_to = 1'b0;
    return v;
  endfunction

  task automatic check(input string name);
    vec_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    if ({irq_valid, irq_id, irq_level, irq_priv, kill_req, claim_valid, claim_id, kill_timeout} !==
        {e.e_v, e.e_id, e.e_lvl, e.e_pr, e.e_kill, e.e_claim, e.e_cid, e.e_to}) begin
      n_fail++;
      $display("FAIL %s: got v=%0b id=%0d lvl=%0h pr=%0d kill=%0b claim=%0b cid=%0d to=%0b, expected v=%0b id=%0d lvl=%0h pr=%0d kill=%0b claim=%0b cid=%0d to=%0b",
               name, irq_valid, irq_id, irq_level, irq_priv, kill_req, claim_valid, claim_id, kill_timeout,
               e.e_v, e.e_id, e.e_lvl, e.e_pr, e.e_kill, e.e_claim, e.e_cid, e.e_to);
    end
  endtask

  task automatic drive(input vec_t v, input string name);
    @(negedge clk);
    arb_valid = v.av; arb_id = v.id; arb_level = v.lvl; arb_priv = v.pr;
    irq_ready = v.rdy; kill_ack = v.ack;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z, v;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // present and claim
    vecs.push_back(mk(1, 5, 'h80, 3, 0, 0,  1, 5, 'h80, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,     0, 0, 0, 0, 0, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0));
    // preempt by winner change, ack two cycles later
    vecs.push_back(mk(1, 5, 'h40, 1, 0, 0,  1, 5, 'h40, 1, 0, 0, 0));
    vecs.push_back(mk(1, 5, 'h40, 1, 0, 0,  1, 5, 'h40, 1, 0, 0, 0));
    vecs.push_back(mk(1, 9, 'h22, 3, 0, 0,  0, 5, 'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 9, 'h22, 3, 0, 0,  0, 5, 'h40, 1, 1, 0, 0));
    vecs.push_back(mk(1, 9, 'h22, 3, 0, 1,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 'h22, 3, 0, 0,  1, 9, 'h22, 3, 0, 0, 0));
    // race: ready and ack together in KILL
    vecs.push_back(mk(1, 12, 'h10, 1, 0, 0, 0, 9, 'h22, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,     0, 0, 0, 0, 0, 1, 9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0));
    // winner vanishes
    vecs.push_back(mk(1, 7, 'h55, 3, 0, 0,  1, 7, 'h55, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0, 7, 'h55, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0, 0));
    // ready together with winner change: claim, no kill
    vecs.push_back(mk(1, 20, 'h01, 1, 0, 0, 1, 20, 'h01, 1, 0, 0, 0));
    vecs.push_back(mk(1, 21, 'h02, 1, 1, 0, 0, 0, 0, 0, 0, 1, 20));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0));
    // ack outside KILL is ignored
    vecs.push_back(mk(1, 30, 'h99, 3, 0, 0, 1, 30, 'h99, 3, 0, 0, 0));
    vecs.push_back(mk(1, 30, 'h99, 3, 0, 1, 1, 30, 'h99, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,     0, 0, 0, 0, 0, 1, 30));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(z);
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset in the middle of a kill handshake
    drive(mk(1, 40, 'h44, 3, 0, 0, 1, 40, 'h44, 3, 0, 0, 0), "rst_access");
    drive(mk(0, 0, 0, 0, 0, 0,     0, 40, 'h44, 3, 1, 0, 0), "rst_kill");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(z);
    check("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1, 3, 'h33, 3, 0, 0, 1, 3, 'h33, 3, 0, 0, 0), "rst_represent");

    // long kill without ack or ready
    drive(mk(0, 0, 0, 0, 0, 0, 0, 3, 'h33, 3, 1, 0, 0), "to_kill0");
    for (int k = 1; k <= 6; k++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 3, 'h33, 3, 1, 0, 0);
      v.e_to = ToEn && (k >= 4);
      drive(v, $sformatf("to_kill%0d", k));
    end
    v = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    v.e_to = ToEn;
    drive(v, "to_ack_idle");
    v = mk(1, 8, 'h0f, 1, 0, 0, 1, 8, 'h0f, 1, 0, 0, 0);
    v.e_to = ToEn;
    drive(v, "to_sticky_access");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
